// File: rtl/xsip_enable_sequencer.sv
// XR module enable sequencer: brings masked modules up one at a time with ready handshake,
// settle window, timeout retry with backoff, sticky fault and reverse-order rollback on abort.
`timescale 1ns/1ps
module xsip_enable_sequencer #(
   parameter int NUM_MOD   = 6,
   parameter int TIMEOUT   = 1000,
   parameter int SETTLE    = 4,
   parameter int BACKOFF   = 8,
   parameter int MAX_RETRY = 2,
   localparam int IW       = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [NUM_MOD-1:0] mod_mask_i,
   input  logic [NUM_MOD-1:0] mod_ready_i,
   output logic [NUM_MOD-1:0] mod_enable_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               fault_o,
   output logic [IW-1:0]      fault_idx_o,
   output logic [IW-1:0]      cur_idx_o,
   output logic [2:0]         retry_cnt_o
);

   localparam int TW = $clog2(TIMEOUT + SETTLE + BACKOFF);

   typedef logic [NUM_MOD-1:0] vec_t;
   typedef logic [IW:0]        idx_t;
   typedef logic [TW-1:0]      tmr_t;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SEL      = 3'd1,
      S_WAIT     = 3'd2,
      S_SETTLE   = 3'd3,
      S_BACKOFF  = 3'd4,
      S_DONE     = 3'd5,
      S_FAULT    = 3'd6,
      S_ROLLBACK = 3'd7
   } state_t;

   // Index is one bit wider than needed so "past the last module" (NUM_MOD) is representable.
   function automatic idx_t next_set_idx(input vec_t m, input idx_t from);
      idx_t r;
      r = idx_t'(NUM_MOD);
      for (int i = NUM_MOD - 1; i >= 0; i--) begin
         if (m[i] && (idx_t'(i) >= from)) begin
            r = idx_t'(i);
         end
      end
      return r;
   endfunction

   function automatic vec_t drop_highest(input vec_t v);
      vec_t r;
      logic found;
      r     = v;
      found = 1'b0;
      for (int i = NUM_MOD - 1; i >= 0; i--) begin
         if (!found && v[i]) begin
            r[i]  = 1'b0;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   state_t     state_q, state_d;
   vec_t       mask_q, mask_d;
   vec_t       en_q, en_d;
   idx_t       idx_q, idx_d;
   logic [2:0] retry_q, retry_d;
   tmr_t       tmr_q, tmr_d;
   logic [IW-1:0] fidx_q, fidx_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       fault_q, fault_d;

   vec_t       cur_bit_s;
   vec_t       rb_en_s;
   logic       rdy_cur_s;
   logic       timeout_s;
   idx_t       nxt_s;

   assign cur_bit_s = vec_t'(1) << idx_q;
   assign rdy_cur_s = |(mod_ready_i & cur_bit_s);
   assign nxt_s     = next_set_idx(mask_q, idx_q);
   assign rb_en_s   = drop_highest(en_q);

   // Next-state and datapath decode; abort overrides everything except IDLE/ROLLBACK.
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      en_d      = en_q;
      idx_d     = idx_q;
      retry_d   = retry_q;
      tmr_d     = tmr_q;
      fidx_d    = fidx_q;
      timeout_s = 1'b0;

      case (state_q)
         S_IDLE, S_DONE, S_FAULT: begin
            if (start_i) begin
               mask_d  = mod_mask_i;
               en_d    = '0;
               idx_d   = '0;
               retry_d = 3'd0;
               tmr_d   = '0;
               fidx_d  = '0;
               state_d = S_SEL;
            end else begin
               state_d = state_q;
            end
         end
         S_SEL: begin
            if (nxt_s >= idx_t'(NUM_MOD)) begin
               state_d = S_DONE;
            end else begin
               idx_d   = nxt_s;
               en_d    = en_q | (vec_t'(1) << nxt_s);
               tmr_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (rdy_cur_s) begin
               tmr_d   = '0;
               state_d = S_SETTLE;
            end else if (tmr_q == tmr_t'(TIMEOUT - 1)) begin
               timeout_s = 1'b1;
            end else begin
               tmr_d = tmr_q + tmr_t'(1);
            end
         end
         S_SETTLE: begin
            if (!rdy_cur_s) begin
               timeout_s = 1'b1;
            end else if (tmr_q == tmr_t'(SETTLE - 1)) begin
               idx_d   = idx_q + idx_t'(1);
               retry_d = 3'd0;
               tmr_d   = '0;
               state_d = S_SEL;
            end else begin
               tmr_d = tmr_q + tmr_t'(1);
            end
         end
         S_BACKOFF: begin
            if (tmr_q == tmr_t'(BACKOFF - 1)) begin
               en_d    = en_q | cur_bit_s;
               tmr_d   = '0;
               state_d = S_WAIT;
            end else begin
               tmr_d = tmr_q + tmr_t'(1);
            end
         end
         S_ROLLBACK: begin
            en_d = rb_en_s;
            if (rb_en_s == '0) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ROLLBACK;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (timeout_s) begin
         if (retry_q < 3'(MAX_RETRY)) begin
            en_d    = en_q & ~cur_bit_s;
            retry_d = retry_q + 3'd1;
            tmr_d   = '0;
            state_d = S_BACKOFF;
         end else begin
            en_d    = '0;
            fidx_d  = idx_q[IW-1:0];
            state_d = S_FAULT;
         end
      end else begin
         timeout_s = 1'b0;
      end

      if (abort_i && (state_q != S_IDLE) && (state_q != S_ROLLBACK)) begin
         mask_d  = mask_q;
         en_d    = en_q;
         idx_d   = idx_q;
         retry_d = retry_q;
         tmr_d   = tmr_q;
         fidx_d  = fidx_q;
         state_d = S_ROLLBACK;
      end else begin
         mask_d = mask_d;
      end

      busy_d  = (state_d == S_SEL) || (state_d == S_WAIT) || (state_d == S_SETTLE) ||
                (state_d == S_BACKOFF) || (state_d == S_ROLLBACK);
      done_d  = (state_d == S_DONE);
      fault_d = (state_d == S_FAULT);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mask_q  <= '0;
         en_q    <= '0;
         idx_q   <= '0;
         retry_q <= 3'd0;
         tmr_q   <= '0;
         fidx_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         en_q    <= en_d;
         idx_q   <= idx_d;
         retry_q <= retry_d;
         tmr_q   <= tmr_d;
         fidx_q  <= fidx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fault_q <= fault_d;
      end
   end

   assign mod_enable_o = en_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign fault_o      = fault_q;
   assign fault_idx_o  = fidx_q;
   assign cur_idx_o    = idx_q[IW-1:0];
   assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_xsip_enable_sequencer.sv
// Bench for xsip_enable_sequencer: a timeline model derives per-cycle expected outputs and
// ready stimulus from each module's per-attempt response plan; one process compares every cycle.
`timescale 1ns/1ps
module tb_xsip_enable_sequencer;
   localparam int NM = 6, TO = 16, ST = 4, BO = 8, MR = 2, N = 256;

   logic       clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, abort_i = 1'b0;
   logic [5:0] mod_mask_i = 6'd0, mod_ready_i = 6'd0;
   logic [5:0] mod_enable_o;
   logic       busy_o, done_o, fault_o;
   logic [2:0] fault_idx_o, cur_idx_o, retry_cnt_o;

   xsip_enable_sequencer #(.NUM_MOD(NM), .TIMEOUT(TO), .SETTLE(ST), .BACKOFF(BO),
                           .MAX_RETRY(MR)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
      .mod_mask_i(mod_mask_i), .mod_ready_i(mod_ready_i), .mod_enable_o(mod_enable_o),
      .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o), .fault_idx_o(fault_idx_o),
      .cur_idx_o(cur_idx_o), .retry_cnt_o(retry_cnt_o));

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   int end_cyc;
   // Plan: per module, per attempt: ready latency after enable (-1 = never), settle drop cycle (0 = none)
   int lat [6][3];
   int drop[6][3];
   logic [5:0] noise;

   logic [5:0] x_en[N], x_rdy[N];
   bit         x_busy[N], x_done[N], x_fault[N], x_ab[N];
   int         x_fidx[N], x_retry[N], x_cur[N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic clear_plan();
      for (int i = 0; i < 6; i++)
         for (int a = 0; a < 3; a++) begin
            lat[i][a]  = 3;
            drop[i][a] = 0;
         end
   endtask

   task automatic mark_sel(input int t, input logic [5:0] acc);
      x_busy[t] = 1'b1; x_en[t] = acc; x_retry[t] = 0; x_cur[t] = -1;
   endtask

   // Builds the whole expected timeline; cycle 0 is the cycle start is driven high.
   task automatic build(input logic [5:0] m, input int abort_at);
      int t, e, a, d, s, l, k, last, j;
      logic [5:0] acc, r;
      bit ok, failed;
      for (int c = 0; c < N; c++) begin
         x_en[c] = 6'd0; x_rdy[c] = noise & ~m; x_busy[c] = 1'b0; x_done[c] = 1'b0;
         x_fault[c] = 1'b0; x_ab[c] = 1'b0; x_fidx[c] = 0; x_retry[c] = 0; x_cur[c] = -1;
      end
      acc = 6'd0; t = 1; failed = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (m[i] && !failed) begin
            mark_sel(t, acc);
            e = t + 1; a = 0; ok = 1'b0;
            while (!ok && !failed) begin
               l = lat[i][a]; k = drop[i][a]; s = 0; d = 0;
               if (l < 0) d = e + TO - 1;
               else if (k > 0) begin
                  for (int c = e + l; c < e + l + k; c++) x_rdy[c][i] = 1'b1;
                  d = e + l + k;
               end else begin
                  for (int c = e + l; c < N; c++) x_rdy[c][i] = 1'b1;
                  s = e + l + ST;
               end
               last = (l >= 0 && k == 0) ? s : d;
               for (int c = e; c <= last; c++) begin
                  x_busy[c] = 1'b1; x_en[c] = acc | (6'd1 << i); x_cur[c] = i; x_retry[c] = a;
               end
               if (l >= 0 && k == 0) begin
                  acc = acc | (6'd1 << i); t = s + 1; ok = 1'b1;
               end else if (a < MR) begin
                  for (int c = d + 1; c <= d + BO; c++) begin
                     x_busy[c] = 1'b1; x_en[c] = acc; x_cur[c] = i; x_retry[c] = a + 1;
                  end
                  e = d + BO + 1; a++;
               end else begin
                  for (int c = d + 1; c < N; c++) begin
                     x_fault[c] = 1'b1; x_fidx[c] = i; x_retry[c] = a;
                  end
                  end_cyc = d + 1; failed = 1'b1;
               end
            end
         end
      end
      if (!failed) begin
         mark_sel(t, acc);
         for (int c = t + 1; c < N; c++) begin x_done[c] = 1'b1; x_en[c] = acc; end
         end_cyc = t + 1;
      end
      x_cur[1] = 0;
      if (abort_at > 0) begin
         x_ab[abort_at] = 1'b1;
         r = x_en[abort_at];
         j = abort_at + 1;
         do begin
            x_busy[j] = 1'b1; x_done[j] = 1'b0; x_fault[j] = 1'b0; x_en[j] = r;
            for (int b = 5; b >= 0; b--) if (r[b]) begin r[b] = 1'b0; break; end
            j++;
         end while (r != 6'd0);
         for (int c = j; c < N; c++) begin
            x_busy[c] = 1'b0; x_done[c] = 1'b0; x_fault[c] = 1'b0; x_en[c] = 6'd0;
         end
         end_cyc = j;
      end
   endtask

   // Call at #1 after a rising edge; that cycle becomes cycle 0 of the scenario.
   task automatic run_scn(input logic [5:0] m);
      cyc = 0; mod_mask_i = m; start_i = 1'b1; abort_i = 1'b0; mod_ready_i = x_rdy[0];
      chk_en = 1'b1;
      while (cyc < end_cyc + 3) begin
         @(posedge clk); #1;
         cyc++;
         start_i = 1'b0; mod_ready_i = x_rdy[cyc]; abort_i = x_ab[cyc];
      end
      chk_en = 1'b0;
   endtask

   // Single per-cycle comparison against the model timeline.
   always @(negedge clk) begin
      if (chk_en && cyc >= 1) begin
         chk("mod_enable", 32'(mod_enable_o), 32'(x_en[cyc]));
         chk("busy", 32'(busy_o), 32'(x_busy[cyc]));
         chk("done", 32'(done_o), 32'(x_done[cyc]));
         chk("fault", 32'(fault_o), 32'(x_fault[cyc]));
         chk("retry_cnt", 32'(retry_cnt_o), 32'(x_retry[cyc]));
         if (x_fault[cyc]) chk("fault_idx", 32'(fault_idx_o), 32'(x_fidx[cyc]));
         if (x_cur[cyc] >= 0) chk("cur_idx", 32'(cur_idx_o), 32'(x_cur[cyc]));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      noise = 6'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_enable", 32'(mod_enable_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_fault", 32'(fault_o), 32'd0);
      chk("rst_cur_idx", 32'(cur_idx_o), 32'd0);
      chk("rst_retry", 32'(retry_cnt_o), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // All six modules, ready 3 cycles after enable, then abort in DONE.
      clear_plan();
      build(6'h3F, 60);
      chk("pin_s1_en_c46", 32'(x_en[46]), 32'h1F);
      chk("pin_s1_en_c47", 32'(x_en[47]), 32'h3F);
      chk("pin_s1_done_c55", 32'(x_done[55]), 32'd0);
      chk("pin_s1_done_c56", 32'(x_done[56]), 32'd1);
      chk("pin_rb_en_c62", 32'(x_en[62]), 32'h1F);
      chk("pin_rb_en_c66", 32'(x_en[66]), 32'h01);
      chk("pin_rb_busy_c67", 32'(x_busy[67]), 32'd0);
      run_scn(6'h3F);

      // Sparse mask with ready noise on unmasked modules.
      clear_plan();
      noise = 6'b011010;
      build(6'b100101, 0);
      chk("pin_s2_en_c20", 32'(x_en[20]), 32'h25);
      chk("pin_s2_done_c29", 32'(x_done[29]), 32'd1);
      run_scn(6'b100101);
      noise = 6'd0;

      // Module 1 never ready: three attempts then fault.
      clear_plan();
      for (int a = 0; a < 3; a++) lat[1][a] = -1;
      build(6'h3F, 0);
      chk("pin_s3_en_c26", 32'(x_en[26]), 32'h03);
      chk("pin_s3_en_c27", 32'(x_en[27]), 32'h01);
      chk("pin_s3_en_c35", 32'(x_en[35]), 32'h03);
      chk("pin_s3_fault_c75", 32'(x_fault[75]), 32'd1);
      chk("pin_s3_en_c75", 32'(x_en[75]), 32'h00);
      run_scn(6'h3F);

      // Module 3 ready only on its second attempt (restart from FAULT).
      clear_plan();
      lat[3][0] = -1;
      build(6'h3F, 0);
      chk("pin_s4_retry_c53", 32'(x_retry[53]), 32'd1);
      chk("pin_s4_retry_c61", 32'(x_retry[61]), 32'd0);
      run_scn(6'h3F);

      // Module 2 ready drops in the second settle cycle of its first attempt.
      clear_plan();
      drop[2][0] = 2;
      build(6'h3F, 0);
      run_scn(6'h3F);

      // Empty mask.
      clear_plan();
      build(6'h00, 0);
      chk("pin_s6_done_c2", 32'(x_done[2]), 32'd1);
      run_scn(6'h00);

      // Asynchronous reset while module 0 is waiting.
      clear_plan();
      for (int a = 0; a < 3; a++) lat[0][a] = -1;
      build(6'h3F, 0);
      cyc = 0; mod_mask_i = 6'h3F; start_i = 1'b1; mod_ready_i = x_rdy[0]; chk_en = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         cyc++;
         start_i = 1'b0; mod_ready_i = x_rdy[cyc];
      end
      chk_en = 1'b0;
      chk("pre_reset_en", 32'(mod_enable_o), 32'h01);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_en", 32'(mod_enable_o), 32'd0);
      chk("async_rst_busy", 32'(busy_o), 32'd0);
      chk("async_rst_retry", 32'(retry_cnt_o), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
